// File: rtl/gearbox_narrow2wide.sv
// Narrow-to-wide gearbox: packs IN_W-bit beats into OUT_W-bit words, oldest bit in the MSB.
// Define GEARBOX_FLUSH_EN to add the flush/out_last ports that drain a zero-padded partial word.
module gearbox_narrow2wide #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef GEARBOX_FLUSH_EN
  ,
  input  logic             flush,
  output logic             out_last
`endif
);
  localparam int BUF_W = OUT_W + 2*IN_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] C_OUT       = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] C_IN        = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] C_READY_MAX = CNT_W'(OUT_W + IN_W);

  // Valid bits are left-justified in r_buf; everything below them is kept zero.
  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_cnt_p;
  logic [CNT_W-1:0] w_cnt_next;
  logic [BUF_W-1:0] w_buf_p;
  logic [BUF_W-1:0] w_beat;
  logic [BUF_W-1:0] w_buf_next;

  assign out_valid = (r_cnt >= C_OUT);
  assign out_data  = r_buf[BUF_W-1 -: OUT_W];

`ifdef GEARBOX_FLUSH_EN
  logic r_flush_pend;
  logic w_pend_next;

  assign in_ready = (r_cnt <= C_READY_MAX) && !r_flush_pend;
  assign out_last = r_flush_pend && (r_cnt == C_OUT);
`else
  assign in_ready = (r_cnt <= C_READY_MAX);
`endif

  always_comb begin
    w_pop      = out_valid & out_ready;
    w_push     = in_valid & in_ready;
    w_cnt_p    = w_pop ? (r_cnt - C_OUT) : r_cnt;
    w_buf_p    = w_pop ? (r_buf << OUT_W) : r_buf;
    // Zero fill below the valid region lets a plain OR place the new beat.
    w_beat     = {in_data, {(BUF_W-IN_W){1'b0}}} >> w_cnt_p;
    w_buf_next = w_push ? (w_buf_p | w_beat) : w_buf_p;
    w_cnt_next = w_push ? (w_cnt_p + C_IN) : w_cnt_p;
`ifdef GEARBOX_FLUSH_EN
    // Rounding the count up exposes the zero-filled tail as the padded final word.
    if (r_flush_pend && (w_cnt_next != '0) && (w_cnt_next < C_OUT))
      w_cnt_next = C_OUT;
    w_pend_next = r_flush_pend;
    if (r_flush_pend && ((w_pop && out_last) || (r_cnt == '0)))
      w_pend_next = 1'b0;
    if (flush)
      w_pend_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_buf_next;
      r_cnt <= w_cnt_next;
    end
  end

`ifdef GEARBOX_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_flush_pend <= 1'b0;
    else
      r_flush_pend <= w_pend_next;
  end
`endif

endmodule

// File: tb/tb_gearbox_narrow2wide.sv
// Bench for gearbox_narrow2wide: bit-queue reference model, directed and random handshakes,
// on a 24->128 instance and a 40->64 instance.
module tb_gearbox_narrow2wide;
  localparam int P_IN  = 24;
  localparam int P_OUT = 128;
  localparam int Q_IN  = 40;
  localparam int Q_OUT = 64;
  localparam logic [127:0] W0_EXP = {24'h000000, 24'h000001, 24'h000002, 24'h000003, 24'h000004, 8'h00};
  localparam logic [127:0] WR_EXP = {24'hC00000, 24'hC00001, 24'hC00002, 24'hC00003, 24'hC00004, 8'hC0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [P_IN-1:0]  a_in_data  = '0;
  logic             a_in_valid = 1'b0;
  logic             a_in_ready;
  logic [P_OUT-1:0] a_out_data;
  logic             a_out_valid;
  logic             a_out_ready = 1'b0;

  logic [Q_IN-1:0]  b_in_data  = '0;
  logic             b_in_valid = 1'b0;
  logic             b_in_ready;
  logic [Q_OUT-1:0] b_out_data;
  logic             b_out_valid;
  logic             b_out_ready = 1'b0;

`ifdef GEARBOX_FLUSH_EN
  logic a_flush = 1'b0;
  logic a_out_last;
  logic b_out_last;
`endif

  gearbox_narrow2wide #(.IN_W(P_IN), .OUT_W(P_OUT)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
`ifdef GEARBOX_FLUSH_EN
    ,
    .flush     (a_flush),
    .out_last  (a_out_last)
`endif
  );

  gearbox_narrow2wide #(.IN_W(Q_IN), .OUT_W(Q_OUT)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
`ifdef GEARBOX_FLUSH_EN
    ,
    .flush     (1'b0),
    .out_last  (b_out_last)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mq_a[$];
  bit mq_b[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle on instance A: check outputs against the bit queue, drive, clock, update queue.
  task automatic cycle_a(input logic iv, input logic [P_IN-1:0] id, input logic ordy,
                         output logic pushed, output logic popped);
    logic [127:0] head;
    int n;
    logic exp_v, exp_r;
    n     = mq_a.size();
    exp_v = (n >= P_OUT);
    exp_r = (n <= P_OUT + P_IN);
    check("a_out_valid", {127'd0, a_out_valid}, {127'd0, exp_v});
    check("a_in_ready", {127'd0, a_in_ready}, {127'd0, exp_r});
    if (exp_v) begin
      head = '0;
      for (int i = 0; i < P_OUT; i++) head[P_OUT-1-i] = mq_a[i];
      check("a_out_data", {{(128-P_OUT){1'b0}}, a_out_data}, head);
    end
    a_in_valid  = iv;
    a_in_data   = id;
    a_out_ready = ordy;
    pushed = iv & exp_r;
    popped = exp_v & ordy;
    @(posedge clk);
    #1;
    if (popped) for (int i = 0; i < P_OUT; i++) void'(mq_a.pop_front());
    if (pushed) for (int i = P_IN-1; i >= 0; i--) mq_a.push_back(id[i]);
    a_in_valid = 1'b0;
  endtask

  task automatic cycle_b(input logic iv, input logic [Q_IN-1:0] id, input logic ordy);
    logic [127:0] head;
    int n;
    logic exp_v, exp_r;
    n     = mq_b.size();
    exp_v = (n >= Q_OUT);
    exp_r = (n <= Q_OUT + Q_IN);
    check("b_out_valid", {127'd0, b_out_valid}, {127'd0, exp_v});
    check("b_in_ready", {127'd0, b_in_ready}, {127'd0, exp_r});
    if (exp_v) begin
      head = '0;
      for (int i = 0; i < Q_OUT; i++) head[Q_OUT-1-i] = mq_b[i];
      check("b_out_data", {64'd0, b_out_data}, head);
    end
    b_in_valid  = iv;
    b_in_data   = id;
    b_out_ready = ordy;
    @(posedge clk);
    #1;
    if (exp_v && ordy) for (int i = 0; i < Q_OUT; i++) void'(mq_b.pop_front());
    if (iv && exp_r) for (int i = Q_IN-1; i >= 0; i--) mq_b.push_back(id[i]);
    b_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq_a.delete();
    mq_b.delete();
  endtask

  logic pu, po;
  int   pop_at[8];
  int   n_pop;
  int   acc;
  logic ordy;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {127'd0, a_out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, a_in_ready}, 128'd1);
    check("rst_out_data", a_out_data, 128'd0);
    check("rst_b_out_valid", {127'd0, b_out_valid}, 128'd0);
    rst = 1'b0;

    // 16 counting beats back-to-back, sink always ready
    n_pop = 0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 7) check("dir_word0", a_out_data, W0_EXP);
      cycle_a(c <= 16, P_IN'(c-1), 1'b1, pu, po);
      if (po && n_pop < 8) begin
        pop_at[n_pop] = c;
        n_pop++;
      end
    end
    check("dir_word_count", 128'(n_pop), 128'd3);
    check("dir_word0_cycle", 128'(pop_at[0]), 128'd7);
    check("dir_word1_cycle", 128'(pop_at[1]), 128'd12);
    check("dir_word2_cycle", 128'(pop_at[2]), 128'd17);
    check("dir_empty_valid", {127'd0, a_out_valid}, 128'd0);
    $display("dir_stream: words=%0d at cycles %0d %0d %0d", n_pop, pop_at[0], pop_at[1], pop_at[2]);

    // Sink stalled: in_ready must drop after the buffer fills, data must hold
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_in_ready) acc++;
      cycle_a(1'b1, P_IN'($urandom()), 1'b0, pu, po);
    end
    check("stall_accepted", 128'(acc), 128'(((P_OUT + P_IN) / P_IN) + 1));
    check("stall_in_ready_low", {127'd0, a_in_ready}, 128'd0);
    $display("stall: beats accepted=%0d", acc);
    for (int c = 0; c < 40; c++) cycle_a(1'($urandom()), P_IN'($urandom()), 1'b1, pu, po);
    for (int c = 0; c < 10; c++) cycle_a(1'b0, '0, 1'b1, pu, po);

    // Reset mid-word discards partial data
    do_reset();
    for (int c = 0; c < 3; c++) cycle_a(1'b1, P_IN'($urandom()), 1'b1, pu, po);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq_a.delete();
    check("midrst_out_valid", {127'd0, a_out_valid}, 128'd0);
    check("midrst_in_ready", {127'd0, a_in_ready}, 128'd1);
    for (int c = 0; c < 6; c++) cycle_a(1'b1, P_IN'(24'hC00000 + c), 1'b1, pu, po);
    check("midrst_word_valid", {127'd0, a_out_valid}, 128'd1);
    check("midrst_word", a_out_data, WR_EXP);
    $display("midrst: word=%h", a_out_data);
    cycle_a(1'b0, '0, 1'b1, pu, po);

`ifdef GEARBOX_FLUSH_EN
    // Flush of a 48-bit partial word
    do_reset();
    cycle_a(1'b1, 24'hAAAAAA, 1'b0, pu, po);
    cycle_a(1'b1, 24'h555555, 1'b0, pu, po);
    a_flush = 1'b1;
    @(posedge clk);
    #1;
    a_flush = 1'b0;
    check("flush_in_ready_low", {127'd0, a_in_ready}, 128'd0);
    acc = 0;
    while (!a_out_valid && acc < 10) begin
      @(posedge clk);
      #1;
      acc++;
    end
    check("flush_valid", {127'd0, a_out_valid}, 128'd1);
    check("flush_word", a_out_data, {48'hAAAAAA555555, 80'd0});
    check("flush_last", {127'd0, a_out_last}, 128'd1);
    $display("flush: word=%h last=%0b", a_out_data, a_out_last);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("flush_done_valid", {127'd0, a_out_valid}, 128'd0);
    check("flush_in_ready_back", {127'd0, a_in_ready}, 128'd1);
    mq_a.delete();
`endif

    // Random handshakes, 24->128
    do_reset();
    for (int c = 0; c < 800; c++) begin
      ordy = ($urandom_range(0, 9) < (((c / 100) % 2) == 1 ? 3 : 8));
      cycle_a($urandom_range(0, 3) != 0, P_IN'($urandom()), ordy, pu, po);
    end
    $display("rand_a: residue bits=%0d", mq_a.size());

    // Random handshakes, 40->64
    for (int c = 0; c < 600; c++) begin
      ordy = ($urandom_range(0, 9) < (((c / 80) % 2) == 1 ? 4 : 9));
      cycle_b($urandom_range(0, 3) != 0, Q_IN'({$urandom(), $urandom()}), ordy);
    end
    $display("rand_b: residue bits=%0d", mq_b.size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
